// File: rtl/weight_lut_pkg.sv
// Shared types and table layout for the weight LUT streamer.
package weight_lut_pkg;

    localparam int unsigned TID_BITS   = 5;
    localparam int unsigned NUM_TABLES = 18;

    typedef enum logic [TID_BITS-1:0] {
        CLASSIFIER_BS = 5'd1,
        CLASSIFIER_WT = 5'd2,
        EMBEDDING_BS  = 5'd3,
        EMBEDDING_WT  = 5'd4,
        CLS_TOKEN     = 5'd5,
        FINAL_BS      = 5'd6,
        FINAL_WT      = 5'd7,
        KEYS_BS       = 5'd8,
        KEYS_WT       = 5'd9,
        QUERIES_BS    = 5'd10,
        QUERIES_WT    = 5'd11,
        VALUES_BS     = 5'd12,
        VALUES_WT     = 5'd13,
        MLP0_BS       = 5'd14,
        MLP0_WT       = 5'd15,
        MLP1_BS       = 5'd16,
        MLP1_WT       = 5'd17,
        PS_WT         = 5'd18
    } table_id_e;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StErr,
        StFetch,
        StDrain,
        StDone
    } state_e;

    // Entry 0 is the reserved id and holds no data.
    localparam int unsigned TBL_SIZE [NUM_TABLES+1] = '{
        0, 16, 128, 16, 64, 16, 16, 256, 16, 256, 16, 256, 16, 256, 16, 256, 16, 256, 64
    };
    localparam int unsigned TBL_BASE [NUM_TABLES+1] = '{
        0, 0, 16, 144, 160, 224, 240, 256, 512, 528, 784, 800, 1056, 1072, 1328, 1344,
        1600, 1616, 1872
    };

    localparam int unsigned ROM_DEPTH = 1936;
    localparam int unsigned ROM_AW    = $clog2(ROM_DEPTH);
    // Image name used when the bank is swapped for a file-initialised macro.
    localparam string       ROM_INIT_FILE = "weight_rom.mem";

    function automatic logic [31:0] tbl_size(input logic [TID_BITS-1:0] id);
        return (id >= 5'd1 && id <= 5'd18) ? TBL_SIZE[id] : 32'd0;
    endfunction

    function automatic logic [31:0] tbl_base(input logic [TID_BITS-1:0] id);
        return (id >= 5'd1 && id <= 5'd18) ? TBL_BASE[id] : 32'd0;
    endfunction

    // Procedural weight image: entry at global address a.
    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return (addr * 32'd37 + 32'd11) ^ (addr >> 3);
    endfunction

endpackage

// File: rtl/weight_rom_bank.sv
// LANES-wide ROM bank with a 1-cycle synchronous read of consecutive entries.
module weight_rom_bank
    import weight_lut_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANES      = 4,
    parameter int unsigned ADDR_WIDTH = ROM_AW
) (
    input  logic                          i_clk,
    input  logic                          i_rd_en,
    input  logic [ADDR_WIDTH-1:0]         i_rd_addr,
    output logic [LANES*DATA_WIDTH-1:0]   o_rd_data
);

    logic [LANES*DATA_WIDTH-1:0] r_data;

    // Register LANES consecutive entries starting at the requested address.
    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            for (int k = 0; k < LANES; k++) begin
                r_data[k*DATA_WIDTH +: DATA_WIDTH] <=
                    DATA_WIDTH'(rom_word(32'(i_rd_addr) + 32'(k)));
            end
        end
    end

    assign o_rd_data = r_data;

endmodule

// File: rtl/weight_lut_streamer.sv
// Command-driven weight streamer: range-checks a table request, then streams
// LANES entries per beat over valid/ready through a 2-entry skid FIFO.
module weight_lut_streamer
    import weight_lut_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANES      = 4,
    parameter int unsigned TID_WIDTH  = 5,
    parameter int unsigned IDX_WIDTH  = 16,
    parameter int unsigned LEN_WIDTH  = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [TID_WIDTH-1:0]          table_id,
    input  logic [IDX_WIDTH-1:0]          base_idx,
    input  logic [LEN_WIDTH-1:0]          len,
    output logic                          busy,
    output logic [LANES*DATA_WIDTH-1:0]   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic                          done,
    output logic                          err
);

    localparam int unsigned EXT_WIDTH = IDX_WIDTH + LEN_WIDTH + 2;
    localparam int unsigned BEAT_W    = LANES * DATA_WIDTH;

    state_e                 r_state;
    state_e                 w_state_next;

    logic [TID_WIDTH-1:0]   r_cmd_id;
    logic [IDX_WIDTH-1:0]   r_cmd_base;
    logic [LEN_WIDTH-1:0]   r_cmd_len;
    logic [ROM_AW-1:0]      r_addr;
    logic [LEN_WIDTH-1:0]   r_issue_cnt;
    logic                   r_rd_vld;
    logic                   r_rd_last;

    logic [BEAT_W-1:0]      r_fifo_data [2];
    logic                   r_fifo_last [2];
    logic                   r_wr_ptr;
    logic                   r_rd_ptr;
    logic [1:0]             r_count;

    logic                   w_id_ok;
    logic [EXT_WIDTH-1:0]   w_end;
    logic [EXT_WIDTH-1:0]   w_tbl_size;
    logic                   w_cmd_err;
    logic [ROM_AW-1:0]      w_start_addr;
    logic                   w_credit_ok;
    logic                   w_issue;
    logic                   w_issue_last;
    logic [BEAT_W-1:0]      w_rom_data;
    logic                   w_fifo_empty;
    logic                   w_push;
    logic                   w_pop;
    logic [BEAT_W-1:0]      w_head_data;
    logic                   w_head_last;

    weight_rom_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES),
        .ADDR_WIDTH (ROM_AW)
    ) u_rom (
        .i_clk      (clk),
        .i_rd_en    (w_issue),
        .i_rd_addr  (r_addr),
        .o_rd_data  (w_rom_data)
    );

    // Range check in widened arithmetic so base + len*LANES cannot wrap.
    always_comb begin
        w_id_ok      = (r_cmd_id != '0) && (r_cmd_id <= TID_WIDTH'(NUM_TABLES));
        w_tbl_size   = EXT_WIDTH'(tbl_size(TID_BITS'(r_cmd_id)));
        w_end        = EXT_WIDTH'(r_cmd_base) + EXT_WIDTH'(r_cmd_len) * EXT_WIDTH'(LANES);
        w_cmd_err    = !w_id_ok || (r_cmd_len == '0) || (w_end > w_tbl_size);
        w_start_addr = ROM_AW'(tbl_base(TID_BITS'(r_cmd_id)) + 32'(r_cmd_base));
        // A read may issue only if its beat is guaranteed a FIFO slot on arrival.
        w_credit_ok  = (r_count == 2'd0) || ((r_count == 2'd1) && !r_rd_vld);
        w_issue      = (r_state == StFetch) && w_credit_ok;
        w_issue_last = (r_issue_cnt == r_cmd_len - LEN_WIDTH'(1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_next = StCheck;
            StCheck: w_state_next = w_cmd_err ? StErr : StFetch;
            StErr:   w_state_next = StIdle;
            StFetch: if (w_issue && w_issue_last) w_state_next = StDrain;
            StDrain: if (out_valid && out_ready && out_last) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (r_state != StIdle);
        done = (r_state == StDone) || (r_state == StErr);
        err  = (r_state == StErr);
    end

    // Command latch, address/beat counters and read-in-flight tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_id    <= '0;
            r_cmd_base  <= '0;
            r_cmd_len   <= '0;
            r_addr      <= '0;
            r_issue_cnt <= '0;
            r_rd_vld    <= 1'b0;
            r_rd_last   <= 1'b0;
        end else begin
            if (r_state == StIdle && start) begin
                r_cmd_id   <= table_id;
                r_cmd_base <= base_idx;
                r_cmd_len  <= len;
            end
            if (r_state == StCheck) begin
                r_addr      <= w_start_addr;
                r_issue_cnt <= '0;
            end else if (w_issue) begin
                r_addr      <= r_addr + ROM_AW'(LANES);
                r_issue_cnt <= r_issue_cnt + LEN_WIDTH'(1);
            end
            r_rd_vld  <= w_issue;
            r_rd_last <= w_issue && w_issue_last;
        end
    end

    // Head of stream: FIFO entry if any, else the ROM beat arriving this cycle.
    always_comb begin
        w_fifo_empty = (r_count == 2'd0);
        w_head_data  = w_fifo_empty ? w_rom_data : r_fifo_data[r_rd_ptr];
        w_head_last  = w_fifo_empty ? r_rd_last  : r_fifo_last[r_rd_ptr];
        out_valid    = !w_fifo_empty || r_rd_vld;
        out_data     = out_valid ? w_head_data : '0;
        out_last     = out_valid && w_head_last;
        w_push       = r_rd_vld && !(w_fifo_empty && out_ready);
        w_pop        = !w_fifo_empty && out_ready;
    end

    // Skid FIFO storage and pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= w_rom_data;
                r_fifo_last[r_wr_ptr] <= r_rd_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

endmodule
